// File: rtl/uart_rx_frame_fsm.sv
// UART receive framer: start/data/parity/stop FSM fed by an external mid-bit sampler.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_frame_fsm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    input  logic             bit_valid,
    input  logic             sampled_bit,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             par_err,
    output logic             stp_err,
    output logic             strt_glitch,
    output logic             busy
);

    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state_q, state_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             data_valid_q, data_valid_d;
    logic             stp_err_q, stp_err_d;
    logic             strt_glitch_q, strt_glitch_d;
    logic             fall_edge;

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic mismatch_q, mismatch_d;
    logic par_err_q, par_err_d;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    assign fall_edge = rx_prev_q & ~rx_in;

    always_comb begin
        state_d       = state_q;
        rx_prev_d     = rx_in;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        p_data_d      = p_data_q;
        data_valid_d  = 1'b0;
        stp_err_d     = 1'b0;
        strt_glitch_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        mismatch_d    = mismatch_q;
        par_err_d     = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (fall_edge) begin
                    state_d    = StStart;
`ifdef UART_RX_PARITY_EN
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    mismatch_d = 1'b0;
`endif
                end
            end
            StStart: begin
                if (bit_valid) begin
                    if (!sampled_bit) begin
                        state_d = StData;
                    end else begin
                        state_d       = StIdle;
                        strt_glitch_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (bit_valid) begin
                    // LSB-first: each new bit enters at the MSB and moves down.
                    shift_d = WIDTH'({sampled_bit, shift_q} >> 1);
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_valid) begin
                    mismatch_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_valid) begin
                    state_d   = StIdle;
                    stp_err_d = ~sampled_bit;
`ifdef UART_RX_PARITY_EN
                    par_err_d    = mismatch_q;
                    data_valid_d = sampled_bit & ~mismatch_q;
`else
                    data_valid_d = sampled_bit;
`endif
                    if (data_valid_d) begin
                        p_data_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            rx_prev_q     <= 1'b1;
            cnt_q         <= '0;
            shift_q       <= '0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            stp_err_q     <= 1'b0;
            strt_glitch_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            mismatch_q    <= 1'b0;
            par_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rx_prev_q     <= rx_prev_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            stp_err_q     <= stp_err_d;
            strt_glitch_q <= strt_glitch_d;
`ifdef UART_RX_PARITY_EN
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            mismatch_q    <= mismatch_d;
            par_err_q     <= par_err_d;
`endif
        end
    end

    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign stp_err     = stp_err_q;
    assign strt_glitch = strt_glitch_q;
    assign busy        = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign par_err     = par_err_q;
`else
    assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Directed plus randomized frames for uart_rx_frame_fsm, checked against a frame-level model.
// Follows the same UART_RX_PARITY_EN build choice as the design.
module tb_uart_rx_frame_fsm;

`ifdef UART_RX_PARITY_EN
    localparam bit ParBuilt = 1'b1;
`else
    localparam bit ParBuilt = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       bit_valid;
    logic       sampled_bit;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int dv_n = 0;
    int pe_n = 0;
    int se_n = 0;
    int sg_n = 0;
    logic [7:0] dv_data = '0;
    logic [7:0] exp_pdata = '0;

    uart_rx_frame_fsm #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .bit_valid  (bit_valid),
        .sampled_bit(sampled_bit),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .strt_glitch(strt_glitch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output, away from the active edge.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_n++;
            dv_data = P_DATA;
        end
        if (par_err === 1'b1) pe_n++;
        if (stp_err === 1'b1) se_n++;
        if (strt_glitch === 1'b1) sg_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic line, input logic sample);
        rx_in = line;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bit_valid   = 1'b1;
        sampled_bit = sample;
        @(posedge clk); #1;
        bit_valid   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input string tag, input logic start_s, input logic [7:0] data,
                             input logic pen, input logic typ, input logic pbit,
                             input logic stop);
        int dv0, pe0, se0, sg0;
        logic use_par, mism, e_dv, e_pe, e_se, e_sg;
        dv0 = dv_n; pe0 = pe_n; se0 = se_n; sg0 = sg_n;
        use_par = ParBuilt && pen;
        mism    = use_par && ((($countones(data) + int'(pbit)) % 2) != int'(typ));
        e_sg    = start_s;
        e_dv    = !start_s && stop && !mism;
        e_pe    = !start_s && mism;
        e_se    = !start_s && !stop;

        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        PAR_EN  = pen;
        PAR_TYP = typ;
        drive_bit(1'b0, start_s);
        // Flip the config mid-frame; the frame must keep the values seen at its start.
        PAR_EN  = ~pen;
        PAR_TYP = ~typ;
        check({tag, ".busy_mid"}, 32'(busy), 32'(!start_s));
        if (!start_s) begin
            for (int i = 0; i < 8; i++) drive_bit(data[i], data[i]);
            if (use_par) drive_bit(pbit, pbit);
            drive_bit(stop, stop);
        end
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (e_dv) exp_pdata = data;
        check({tag, ".data_valid"}, 32'(dv_n - dv0), 32'(e_dv));
        check({tag, ".par_err"}, 32'(pe_n - pe0), 32'(e_pe));
        check({tag, ".stp_err"}, 32'(se_n - se0), 32'(e_se));
        check({tag, ".strt_glitch"}, 32'(sg_n - sg0), 32'(e_sg));
        check({tag, ".P_DATA"}, 32'(P_DATA), 32'(exp_pdata));
        check({tag, ".busy_end"}, 32'(busy), 32'(0));
        if (e_dv) check({tag, ".P_DATA_at_pulse"}, 32'(dv_data), 32'(data));
    endtask

    initial begin
        int dv0, pe0, se0, sg0;
        logic [7:0] rd;
        rst = 1'b0; rx_in = 1'b1; bit_valid = 1'b0; sampled_bit = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'(0));
        check("reset.P_DATA", 32'(P_DATA), 32'(0));
        check("reset.data_valid", 32'(data_valid), 32'(0));
        check("reset.par_err", 32'(par_err), 32'(0));
        check("reset.stp_err", 32'(stp_err), 32'(0));
        check("reset.strt_glitch", 32'(strt_glitch), 32'(0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame("a5_even_ok", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame("a5_odd_bad", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame("3c_stop0", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("glitch", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame("5a_after_glitch", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

        // bit_valid while idle must not start a frame
        dv0 = dv_n; pe0 = pe_n; se0 = se_n; sg0 = sg_n;
        bit_valid = 1'b1; sampled_bit = 1'b0;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_bv.busy", 32'(busy), 32'(0));
        check("idle_bv.pulses", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0) + (sg_n - sg0)),
              32'(0));

        // reset after 3 data bits
        PAR_EN = 1'b0;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        check("midrst.busy_before", 32'(busy), 32'(1));
        dv0 = dv_n; pe0 = pe_n; se0 = se_n; sg0 = sg_n;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_pdata = 8'h00;
        check("midrst.busy", 32'(busy), 32'(0));
        check("midrst.P_DATA", 32'(P_DATA), 32'(exp_pdata));
        check("midrst.outs", 32'({data_valid, par_err, stp_err, strt_glitch}), 32'(0));
        rst = 1'b1; rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst.pulses", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0) + (sg_n - sg0)),
              32'(0));
        run_frame("ff_odd_ok", 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);

        run_frame("81_par_en", 1'b0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame("both_err", 1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            rd = 8'($urandom);
            run_frame($sformatf("rand%0d", k), ($urandom_range(0, 7) == 0), rd,
                      1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_fsm.md
UART_RX_FRAME_FSM -- requirements
Module: uart_rx_frame_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rx_in  input  1  serial line, idle high.
REQ-005 SHALL have port bit_valid  input  1  one-cycle strobe at each bit's mid-sample point, from the sampler.
REQ-006 SHALL have port sampled_bit  input  1  sampled bit value; qualified by bit_valid.
REQ-007 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd.
REQ-009 SHALL have port P_DATA  output  WIDTH  last good frame's data.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-011 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-012 SHALL have port stp_err  output  1  one-cycle pulse when the stop bit is sampled 0.
REQ-013 SHALL have port strt_glitch  output  1  one-cycle pulse when the start bit is sampled 1.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement a five-state FSM: IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL register rx_in into rx_prev; falling edge = rx_prev 1 and rx_in 0.
REQ-017 IDLE: on a falling edge, SHALL go to START and latch PAR_EN/PAR_TYP for the whole frame; bit_valid is ignored in IDLE.
REQ-018 START: on bit_valid with sampled_bit 0, SHALL go to DATA; with sampled_bit 1, SHALL pulse strt_glitch the next cycle and return to IDLE.
REQ-019 DATA: each bit_valid SHALL shift sampled_bit into a WIDTH-bit shift register LSB-first and increment a bit counter.
REQ-020 After the WIDTH-th data bit, SHALL go to PARITY if latched PAR_EN is 1, else to STOP; the bit counter clears on leaving DATA.
REQ-021 PARITY: on bit_valid, expected = XOR of shift register (even) or its inverse (odd); SHALL store mismatch in an internal flag; then go to STOP.
REQ-022 STOP: on bit_valid, SHALL return to IDLE and, in the following cycle, drive the end-of-frame pulses per REQ-023..025.
REQ-023 data_valid SHALL be 1 only if the stop bit = 1 and there is no parity mismatch; P_DATA SHALL be loaded from the shift register in the same cycle.
REQ-024 par_err SHALL pulse if the mismatch flag is set, regardless of stop-bit value.
REQ-025 stp_err SHALL pulse if the stop bit = 0; par_err and stp_err may pulse together; data_valid never pulses with either.
REQ-026 P_DATA SHALL hold its value between good frames; it SHALL NOT change on an errored frame.
REQ-027 A falling edge on rx_in outside IDLE SHALL be ignored; IDLE SHALL be able to accept a new start on the cycle after STOP completes.
REQ-028 In every state, cycles without bit_valid SHALL hold state, counter and shift register.

Reset
REQ-029 While rst = 0 at a clock edge: state IDLE, rx_prev 1, counter 0, shift register 0, P_DATA 0, mismatch flag 0, all pulse outputs 0, busy 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no error or valid pulse.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: PARITY state and par_err logic present, per REQ-020..024.
REQ-032 Macro UART_RX_PARITY_EN undefined: PARITY state omitted; PAR_EN and PAR_TYP ports present but ignored; DATA goes directly to STOP; par_err tied 0.

Verification
REQ-033 Frame 0xA5 (LSB-first), PAR_EN 1, PAR_TYP 0, parity bit 0, stop 1 -> data_valid pulse, P_DATA = 0xA5, no errors.
REQ-034 Frame 0xA5, PAR_TYP 1, parity bit 0 -> par_err pulse, no data_valid, P_DATA unchanged.
REQ-035 Frame 0x3C, PAR_EN 0, stop bit 0 -> stp_err pulse only, P_DATA unchanged.
REQ-036 Falling edge, then start sample 1 -> strt_glitch pulse, busy drops, next valid frame 0x5A is received normally.
REQ-037 rst low after 3 data bits -> IDLE, all outputs 0; following frame 0xFF with odd parity bit 1 -> data_valid, P_DATA = 0xFF.
REQ-038 Build without UART_RX_PARITY_EN, PAR_EN 1, frame 0x81 without parity bit -> data_valid, P_DATA = 0x81, par_err never asserted.
